// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage in-order core.
// Tracks run/idle, waits out slow data-memory accesses with a timeout,
// and drives stall, bubble and flush controls for the pipeline registers.
// Also keeps a saturating count of PC-stall cycles.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_stall_o,
    output logic             IFID_stall_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_stall_o,
    output logic             MEMWB_bubble_o,
    output logic             IFID_flush_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] RUN      = 2'b01;
    localparam logic [1:0] MEM_WAIT = 2'b10;
    localparam logic [1:0] ERROR    = 2'b11;

    // Timer value seen on the last unacked wait cycle before giving up.
    localparam logic [7:0] TMR_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [7:0]       wait_tmr_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             timeout_q;
    logic             freeze;
    logic             lu_stall;
    logic             flush;

    // Increment that sticks at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    // Next-state and hazard decode; memory freeze outranks load-use, which outranks branch flush.
    always_comb begin
        freeze    = 1'b0;
        lu_stall  = 1'b0;
        flush     = 1'b0;
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                freeze = 1'b1;
                if (start_i)
                    state_nxt = RUN;
            end
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    // A pending miss wins even over a stop request.
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    if (load_use_i)
                        lu_stall = 1'b1;
                    else if (branch_taken_i)
                        flush = 1'b1;
                    state_nxt = start_i ? RUN : IDLE;
                end
            end
            MEM_WAIT: begin
                if (!mem_ack_i) begin
                    freeze = 1'b1;
                    if (wait_tmr_q == TMR_LAST)
                        state_nxt = ERROR;
                end else begin
                    state_nxt = start_i ? RUN : IDLE;
                end
            end
            ERROR: begin
                // Terminal: only reset leaves this state.
                freeze = 1'b1;
            end
            default: begin
                freeze    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign PC_stall_o     = freeze | lu_stall;
    assign IFID_stall_o   = freeze | lu_stall;
    assign IDEX_bubble_o  = freeze | lu_stall;
    assign EXMEM_stall_o  = freeze;
    assign MEMWB_bubble_o = freeze;
    assign IFID_flush_o   = flush;
    assign mem_timeout_o  = timeout_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign state_o        = state_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Wait timer: held at zero outside MEM_WAIT, so every wait starts fresh.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            wait_tmr_q <= 8'd0;
        else if (state_q != MEM_WAIT)
            wait_tmr_q <= 8'd0;
        else if (!mem_ack_i)
            wait_tmr_q <= wait_tmr_q + 8'd1;
    end

    // Sticky timeout flag, raised on the edge that enters ERROR.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            timeout_q <= 1'b0;
        else if (state_nxt == ERROR)
            timeout_q <= 1'b1;
    end

    // Saturating count of cycles the PC was held while running or waiting on memory.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_q <= '0;
        else if ((state_q == RUN || state_q == MEM_WAIT) && PC_stall_o)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// A driver applies directed vectors just after each rising edge and queues the
// hand-computed response for that cycle; a monitor pops and compares on the
// falling edge.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       load_use_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       mem_req_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       PC_stall_o;
    logic       IFID_stall_o;
    logic       IDEX_bubble_o;
    logic       EXMEM_stall_o;
    logic       MEMWB_bubble_o;
    logic       IFID_flush_o;
    logic       mem_timeout_o;
    logic [3:0] stall_cnt_o;
    logic [1:0] state_o;

    // Output bit order {PC, IFID, IDEX, EXMEM, MEMWB, FLUSH}
    localparam logic [5:0] F  = 6'b111110;
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] LU = 6'b111000;
    localparam logic [5:0] FL = 6'b000001;

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic [5:0] o;
        logic       to;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .load_use_i     (load_use_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .PC_stall_o     (PC_stall_o),
        .IFID_stall_o   (IFID_stall_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .EXMEM_stall_o  (EXMEM_stall_o),
        .MEMWB_bubble_o (MEMWB_bubble_o),
        .IFID_flush_o   (IFID_flush_o),
        .mem_timeout_o  (mem_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] o;
            e = exp_q.pop_front();
            o = {PC_stall_o, IFID_stall_o, IDEX_bubble_o, EXMEM_stall_o, MEMWB_bubble_o, IFID_flush_o};
            n_checks++;
            if (state_o !== e.st || o !== e.o || mem_timeout_o !== e.to || stall_cnt_o !== e.c) begin
                n_fail++;
                $display("FAIL %s: got state=%b outs=%b to=%b cnt=%0d, want state=%b outs=%b to=%b cnt=%0d",
                         e.nm, state_o, o, mem_timeout_o, stall_cnt_o, e.st, e.o, e.to, e.c);
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge and queue its expected response.
    task automatic step(input string nm, input logic rst, input logic st, input logic lu,
                        input logic br, input logic mr, input logic ma,
                        input logic [1:0] es, input logic [5:0] eo, input logic et,
                        input logic [3:0] ec);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        start_i        = st;
        load_use_i     = lu;
        branch_taken_i = br;
        mem_req_i      = mr;
        mem_ack_i      = ma;
        e.nm = nm; e.st = es; e.o = eo; e.to = et; e.c = ec;
        exp_q.push_back(e);
    endtask

    initial begin
        //     name                    rst st lu br mr ma   state  outs to cnt
        step("rst_assert",            0, 0, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("idle_after_rst",        1, 0, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("idle_hold",             1, 0, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("start_sampled",         1, 1, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("run_clean",             1, 1, 0, 0, 0, 0,  2'b01, Z,  0, 0);
        step("loaduse_beats_branch",  1, 1, 1, 1, 0, 0,  2'b01, LU, 0, 0);
        step("after_loaduse",         1, 1, 0, 0, 0, 0,  2'b01, Z,  0, 1);
        step("branch_flush",          1, 1, 0, 1, 0, 0,  2'b01, FL, 0, 1);
        step("mem_hit",               1, 1, 0, 0, 1, 1,  2'b01, Z,  0, 1);
        step("mem_miss_entry",        1, 1, 0, 0, 1, 0,  2'b01, F,  0, 1);
        step("mem_wait1",             1, 1, 0, 0, 1, 0,  2'b10, F,  0, 2);
        step("mem_wait2",             1, 1, 0, 0, 1, 0,  2'b10, F,  0, 3);
        step("mem_ack_release",       1, 1, 0, 0, 1, 1,  2'b10, Z,  0, 4);
        step("back_to_run",           1, 1, 0, 0, 0, 0,  2'b01, Z,  0, 4);
        step("memfreeze_beats_all",   1, 1, 1, 1, 1, 0,  2'b01, F,  0, 4);
        step("wait_ack_stop",         1, 0, 0, 0, 1, 1,  2'b10, Z,  0, 5);
        step("idle_after_ack",        1, 0, 0, 0, 0, 0,  2'b00, F,  0, 5);
        step("restart",               1, 1, 0, 0, 0, 0,  2'b00, F,  0, 5);
        step("run_stop_loaduse",      1, 0, 1, 0, 0, 0,  2'b01, LU, 0, 5);
        step("idle_after_stop",       1, 0, 0, 0, 0, 0,  2'b00, F,  0, 6);
        step("restart2",              1, 1, 0, 0, 0, 0,  2'b00, F,  0, 6);
        step("stop_with_miss",        1, 0, 0, 0, 1, 0,  2'b01, F,  0, 6);
        step("wait_over_idle",        1, 0, 0, 0, 1, 0,  2'b10, F,  0, 7);
        step("tmo_wait2",             1, 0, 0, 0, 1, 0,  2'b10, F,  0, 8);
        step("tmo_wait3",             1, 0, 0, 0, 1, 0,  2'b10, F,  0, 9);
        step("tmo_wait4",             1, 0, 0, 0, 1, 0,  2'b10, F,  0, 10);
        step("error_entered",         1, 1, 0, 0, 1, 1,  2'b11, F,  1, 11);
        step("error_ignores",         1, 1, 1, 1, 0, 0,  2'b11, F,  1, 11);
        step("rst_in_error",          0, 0, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("idle_post_err",         1, 1, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("run_miss",              1, 1, 0, 0, 1, 0,  2'b01, F,  0, 0);
        step("wait_before_rst",       1, 1, 0, 0, 1, 0,  2'b10, F,  0, 1);
        step("rst_mid_wait",          0, 1, 0, 0, 1, 0,  2'b00, F,  0, 0);
        step("idle_req_ignored",      1, 0, 0, 0, 1, 0,  2'b00, F,  0, 0);
        step("idle_stays",            1, 0, 0, 0, 1, 0,  2'b00, F,  0, 0);
        step("start3",                1, 1, 0, 0, 0, 0,  2'b00, F,  0, 0);
        step("run_no_reentry",        1, 1, 0, 0, 0, 0,  2'b01, Z,  0, 0);
        for (int i = 0; i < 20; i++)
            step("sat_loaduse",       1, 1, 1, 0, 0, 0,  2'b01, LU, 0, (i > 15) ? 4'd15 : 4'(i));
        step("sat_hold",              1, 1, 0, 0, 0, 0,  2'b01, Z,  0, 15);

        // Let the monitor drain, with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk_i);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MEM_TIMEOUT, 16, max MEM_WAIT cycles without ack before error (legal range 2..255)
  CNT_W, 16, stall counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i  in  1  single clock, rising edge
  rst_i  in  1  asynchronous, active-low reset
  start_i  in  1  pipeline run enable
  load_use_i  in  1  load-use hazard flag from hazard detection, combinational
  branch_taken_i  in  1  beq resolved taken in ID
  mem_req_i  in  1  EX/MEM holds lw/sw needing dmem
  mem_ack_i  in  1  dmem access complete this cycle
  PC_stall_o  out  1  hold PC
  IFID_stall_o  out  1  hold IF/ID
  IDEX_bubble_o  out  1  zero ID/EX control
  EXMEM_stall_o  out  1  hold EX/MEM
  MEMWB_bubble_o  out  1  zero MEM/WB control
  IFID_flush_o  out  1  clear IF/ID
  mem_timeout_o  out  1  sticky dmem timeout flag
  stall_cnt_o  out  CNT_W  PC-stall cycle count
  state_o  out  2  registered FSM state
REQ-003 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM SHALL have four states: IDLE=00, RUN=01, MEM_WAIT=10, ERROR=11; state_o SHALL equal the registered state.
REQ-005 The stall/flush outputs SHALL be combinational from the registered state and current inputs.
REQ-006 "Freeze" SHALL mean PC_stall_o, IFID_stall_o, IDEX_bubble_o, EXMEM_stall_o and MEMWB_bubble_o all 1, with IFID_flush_o 0.
REQ-007 IDLE SHALL freeze; start_i=1 SHALL move to RUN on the next edge.
REQ-008 RUN: mem_req_i=1 with mem_ack_i=0 SHALL freeze in the same cycle, and SHALL move to MEM_WAIT with the wait timer cleared to 0.
REQ-009 RUN: mem_req_i=1 with mem_ack_i=1 in the same cycle SHALL cause no freeze; state SHALL remain RUN.
REQ-010 RUN with no memory freeze and load_use_i=1 SHALL assert PC_stall_o, IFID_stall_o and IDEX_bubble_o only; IFID_flush_o SHALL be 0 even if branch_taken_i=1.
REQ-011 RUN with no memory freeze, load_use_i=0 and branch_taken_i=1 SHALL assert IFID_flush_o only.
REQ-012 Priority SHALL be memory freeze > load-use stall > branch flush.
REQ-013 RUN with start_i=0 SHALL apply normal RUN outputs that cycle, then move to IDLE; if a memory freeze applies that cycle, MEM_WAIT SHALL take precedence over IDLE.
REQ-014 MEM_WAIT SHALL freeze while mem_ack_i=0, incrementing the wait timer by 1 per cycle.
REQ-015 MEM_WAIT with mem_ack_i=1 SHALL deassert every output that cycle, and SHALL return to RUN if start_i=1 or to IDLE if start_i=0.
REQ-016 In MEM_WAIT, when the wait timer equals MEM_TIMEOUT-1 and mem_ack_i=0, the next state SHALL be ERROR; the block therefore enters ERROR after exactly MEM_TIMEOUT unacked wait cycles.
REQ-017 ERROR SHALL freeze, hold mem_timeout_o=1, and ignore all inputs; only reset SHALL exit ERROR.
REQ-018 stall_cnt_o SHALL increment by 1 on each edge where the state is RUN or MEM_WAIT and PC_stall_o=1.
REQ-019 stall_cnt_o SHALL saturate at all ones and SHALL NOT wrap.
REQ-020 Wait timer width SHALL be 8 bits; the timer SHALL NOT increment outside MEM_WAIT.

Reset
REQ-021 rst_i=0 SHALL immediately, without a clock edge, set state=IDLE, wait timer=0, stall_cnt_o=0 and mem_timeout_o=0; outputs SHALL therefore show freeze.
REQ-022 Reset asserted in any state, including mid-MEM_WAIT and ERROR, SHALL abort the operation with no residual state.
REQ-023 After reset release, the block SHALL remain in IDLE until start_i=1 is sampled.

Verification
REQ-024 Reset, then start_i=1: state_o 00 -> 01 after one edge; all stall outputs 0 in RUN with no hazards.
REQ-025 RUN, load_use_i=1 and branch_taken_i=1 for one cycle -> PC_stall_o=IFID_stall_o=IDEX_bubble_o=1, IFID_flush_o=0; stall_cnt_o increments 0 -> 1.
REQ-026 RUN, mem_req_i=1, then mem_ack_i=1 on the 3rd MEM_WAIT cycle -> freeze for 3 cycles (entry plus 2 wait cycles), released in the ack cycle; state 01 -> 10 -> 01; stall_cnt_o=3.
REQ-027 MEM_TIMEOUT=4, mem_req_i=1, never acked -> state_o=11 after 4 MEM_WAIT cycles; mem_timeout_o=1 stays set until rst_i=0, then clears.
REQ-028 CNT_W=4, load_use_i held at 1 for 20 RUN cycles -> stall_cnt_o stops at 15.
REQ-029 rst_i pulsed low mid-MEM_WAIT -> state_o=00 and counters 0 without a clock edge; MEM_WAIT is not re-entered without a new mem_req_i in RUN.
